multicycle_mem_responder: RTL and testbench

MULTICYCLE_MEM_RESPONDER -- requirements
Module: multicycle_mem_responder

---
 rtl/multicycle_mem_responder.sv | 173 +++++++++++++++++
 tb/tb_multicycle_mem_responder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_mem_responder.sv
// ----------------------------------------------------------------------------
// multicycle_mem_responder
//
// Word-addressed memory that sits behind a multicycle CPU controller. It
// accepts one read or write request in IDLE, optionally stretches the access
// with wait states, and reports completion with a one-cycle MemReady pulse.
// Bad addresses complete normally but raise MemErr alongside MemReady.
//
// Build option:
//   MULTICYCLE_MEM_WAIT_EN  defined   -> WAIT state and latency counter are
//                                        built; MemReady comes LATENCY+1 cycles
//                                        after the accept edge.
//                           undefined -> fixed response: MemReady in the cycle
//                                        after accept; LATENCY is ignored.
//
// Parameters:
//   DEPTH    memory size in 32-bit words (power of two)
//   AW       word-index width, log2(DEPTH)
//   LATENCY  extra wait cycles per access (0..15)
//
// Ports:
//   clk       in   single clock, rising edge
//   rst       in   asynchronous active-high reset
//   adr       in   32-bit byte address
//   wdata     in   32-bit store data
//   MemRead   in   read request level
//   MemWrite  in   write request level
//   rdata     out  read data, held until the next completed read
//   MemReady  out  one-cycle completion pulse (registered)
//   MemErr    out  one-cycle error pulse (registered)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for exactly one of MemRead/MemWrite
// WAIT  | counting down wait cycles (only with MULTICYCLE_MEM_WAIT_EN)
// DONE  | MemReady high for one cycle; a write commits on the exit edge
// ----------------------------------------------------------------------------
module multicycle_mem_responder #(
    parameter int DEPTH   = 1024,
    parameter int AW      = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] adr,
    input  logic [31:0] wdata,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] rdata,
    output logic        MemReady,
    output logic        MemErr
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    if (DEPTH != (1 << AW)) begin : g_bad_depth
        $error("multicycle_mem_responder: DEPTH must equal 2**AW");
    end
    if (LATENCY < 0 || LATENCY > 15) begin : g_bad_latency
        $error("multicycle_mem_responder: LATENCY must be in 0..15");
    end

    logic [1:0]    r_state;
    logic [1:0]    w_next;
    logic [31:0]   r_adr;
    logic [31:0]   r_wdata;
    logic          r_wr;
    logic [31:0]   r_rdata;
    logic          r_ready;
    logic          r_err;
    logic [31:0]   r_mem [DEPTH];

    logic          w_idle;
    logic          w_req_rd;
    logic          w_req_wr;
    logic          w_accept;
    logic          w_both;
    logic [31:0]   w_cur_adr;
    logic          w_cur_wr;
    logic          w_cur_bad;
    logic [AW-1:0] w_cur_idx;
    logic          w_enter_done;

    assign w_idle   = (r_state == S_IDLE);
    assign w_req_rd = MemRead & ~MemWrite;
    assign w_req_wr = MemWrite & ~MemRead;
    assign w_accept = w_idle & (w_req_rd | w_req_wr);
    assign w_both   = w_idle & MemRead & MemWrite;

    // The access being finished: in IDLE the direct IDLE->DONE path has not
    // latched anything yet, so the live inputs are used; otherwise the
    // latched request is used.
    assign w_cur_adr = w_idle ? adr      : r_adr;
    assign w_cur_wr  = w_idle ? w_req_wr : r_wr;
    assign w_cur_idx = w_cur_adr[AW+1:2];
    assign w_cur_bad = (w_cur_adr[1:0] != 2'b00) || ((w_cur_adr >> (AW + 2)) != 32'd0);

`ifdef MULTICYCLE_MEM_WAIT_EN
    localparam logic [3:0] LAT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    logic [3:0] r_cnt;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = (LATENCY > 0) ? S_WAIT : S_DONE;
            S_WAIT: if (r_cnt == 4'd0) w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 4'd0;
        end else if (w_accept) begin
            r_cnt <= LAT_LOAD;
        end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end
`else
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end
`endif

    assign w_enter_done = (w_next == S_DONE) && (r_state != S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_adr   <= 32'd0;
            r_wdata <= 32'd0;
            r_wr    <= 1'b0;
            r_rdata <= 32'd0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_adr   <= adr;
                r_wdata <= wdata;
                r_wr    <= w_req_wr;
            end
            r_ready <= w_enter_done;
            r_err   <= (w_enter_done && w_cur_bad) || w_both;
            if (w_enter_done && !w_cur_wr) begin
                r_rdata <= w_cur_bad ? 32'd0 : r_mem[w_cur_idx];
            end
        end
    end

    // Memory survives reset. An aborted write never reaches DONE, because
    // reset forces the state back to IDLE before the commit edge.
    always_ff @(posedge clk) begin
        if (r_state == S_DONE && r_wr && !w_cur_bad) begin
            r_mem[w_cur_idx] <= r_wdata;
        end
    end

    assign rdata    = r_rdata;
    assign MemReady = r_ready;
    assign MemErr   = r_err;

endmodule

// File: tb/tb_multicycle_mem_responder.sv
// Directed bench for multicycle_mem_responder. Runs in either build; the
// expected latency follows MULTICYCLE_MEM_WAIT_EN with LATENCY fixed at 3.
module tb_multicycle_mem_responder;

`ifdef MULTICYCLE_MEM_WAIT_EN
    localparam int EXP_LAT = 3;
`else
    localparam int EXP_LAT = 0;
`endif

    logic        clk;
    logic        rst;
    logic [31:0] adr;
    logic [31:0] wdata;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] rdata;
    logic        MemReady;
    logic        MemErr;

    int n_chk = 0;
    int n_err = 0;

    multicycle_mem_responder #(
        .DEPTH  (1024),
        .AW     (10),
        .LATENCY(3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .adr     (adr),
        .wdata   (wdata),
        .MemRead (MemRead),
        .MemWrite(MemWrite),
        .rdata   (rdata),
        .MemReady(MemReady),
        .MemErr  (MemErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request at a negedge, accept on the next posedge, then scan
    // negedges for MemReady. lat is the number of edges after accept (-1 on
    // timeout).
    task automatic run_op(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input bit hold, output int lat,
                          output logic [31:0] rdo, output logic erro);
        @(negedge clk);
        MemRead  = rd;
        MemWrite = wr;
        adr      = a;
        wdata    = d;
        @(posedge clk);
        lat  = -1;
        rdo  = 'x;
        erro = 1'bx;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!hold) begin
                MemRead  = 1'b0;
                MemWrite = 1'b0;
            end
            if (MemReady) begin
                lat  = k;
                rdo  = rdata;
                erro = MemErr;
                break;
            end
        end
        MemRead  = 1'b0;
        MemWrite = 1'b0;
    endtask

    task automatic do_wr(input string tag, input logic [31:0] a, input logic [31:0] d,
                         input logic exp_err);
        int          lat;
        logic [31:0] rdo;
        logic        erro;
        run_op(1'b0, 1'b1, a, d, 1'b0, lat, rdo, erro);
        chk({tag, "_lat"}, 32'(lat), 32'(EXP_LAT));
        chk({tag, "_err"}, 32'(erro), 32'(exp_err));
    endtask

    task automatic do_rd(input string tag, input logic [31:0] a, input logic [31:0] exp_d,
                         input logic exp_err);
        int          lat;
        logic [31:0] rdo;
        logic        erro;
        run_op(1'b1, 1'b0, a, 32'd0, 1'b0, lat, rdo, erro);
        chk({tag, "_lat"}, 32'(lat), 32'(EXP_LAT));
        chk({tag, "_data"}, rdo, exp_d);
        chk({tag, "_err"}, 32'(erro), 32'(exp_err));
    endtask

    initial begin
        int          lat;
        int          j;
        logic [31:0] rdo;
        logic        erro;

        rst      = 1'b1;
        adr      = 32'd0;
        wdata    = 32'd0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        #12;
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_ready", 32'(MemReady), 32'd0);
        chk("rst_err", 32'(MemErr), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Basic write/read, first request right after reset release
        do_wr("wr10", 32'h10, 32'hDEADBEEF, 1'b0);
        do_wr("wr00", 32'h00, 32'h0BADF00D, 1'b0);
        do_rd("rd10", 32'h10, 32'hDEADBEEF, 1'b0);

        // Held read: one pulse at the exact latency, none afterwards
        run_op(1'b1, 1'b0, 32'h0, 32'd0, 1'b1, lat, rdo, erro);
        chk("hold_lat", 32'(lat), 32'(EXP_LAT));
        chk("hold_data", rdo, 32'h0BADF00D);
        @(negedge clk);
        chk("hold_single_pulse", 32'(MemReady), 32'd0);

        // Both requests high: error next cycle, no access, FSM stays IDLE
        @(negedge clk);
        MemRead  = 1'b1;
        MemWrite = 1'b1;
        adr      = 32'h10;
        wdata    = 32'h0;
        @(posedge clk);
        @(negedge clk);
        chk("both_err", 32'(MemErr), 32'd1);
        chk("both_ready", 32'(MemReady), 32'd0);
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        @(negedge clk);
        chk("both_err_clear", 32'(MemErr), 32'd0);
        chk("both_ready_idle", 32'(MemReady), 32'd0);
        do_rd("both_rd10", 32'h10, 32'hDEADBEEF, 1'b0);

        // Misaligned / out-of-range writes must not touch memory
        do_wr("wr_mis", 32'h12, 32'hFFFFFFFF, 1'b1);
        do_wr("wr_oor", 32'h1000, 32'hFFFFFFFF, 1'b1);
        do_rd("bad_rd10", 32'h10, 32'hDEADBEEF, 1'b0);
        do_rd("bad_rd00", 32'h0, 32'h0BADF00D, 1'b0);
        do_rd("rd_oor", 32'h1000, 32'h0, 1'b1);

        // Reset during an in-flight write abandons it
        do_wr("wr20", 32'h20, 32'hCAFEF00D, 1'b0);
        do_rd("rd20", 32'h20, 32'hCAFEF00D, 1'b0);
        @(negedge clk);
        MemWrite = 1'b1;
        adr      = 32'h20;
        wdata    = 32'h12345678;
        @(posedge clk);
        #1 rst = 1'b1;
        MemWrite = 1'b0;
        #1;
        chk("abort_ready", 32'(MemReady), 32'd0);
        chk("abort_err", 32'(MemErr), 32'd0);
        chk("abort_rdata", rdata, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        do_rd("abort_rd20", 32'h20, 32'hCAFEF00D, 1'b0);

        // Back-to-back reads with MemRead held
        do_wr("wr04", 32'h4, 32'h11112222, 1'b0);
        do_wr("wr08", 32'h8, 32'h33334444, 1'b0);
        @(negedge clk);
        MemRead = 1'b1;
        adr     = 32'h4;
        @(posedge clk);
        lat = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (MemReady) begin
                lat = k;
                break;
            end
        end
        chk("b2b_first_lat", 32'(lat), 32'(EXP_LAT));
        chk("b2b_first_data", rdata, 32'h11112222);
        adr = 32'h8;
        j = -1;
        for (int k = 1; k < 20; k++) begin
            @(negedge clk);
            if (MemReady) begin
                j = k;
                break;
            end
            chk("b2b_hold_data", rdata, 32'h11112222);
        end
        chk("b2b_spacing", 32'(j), 32'(EXP_LAT + 2));
        chk("b2b_second_data", rdata, 32'h33334444);
        MemRead = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
